// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - bimodal branch predictor with branch resolve, redirect and statistics
//
// Purpose: predicts fetch branches from a table of 2-bit saturating counters
// and resolves executed branches. Resolution compares the operands, updates the
// counter, flags a mispredict and supplies the correct next PC one cycle later.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   pred_pc / pred_taken         fetch PC in, combinational prediction out
//   res_valid, res_pc            resolve request and branch PC
//   res_rs1, res_rs2, res_type   compare operands and compare kind
//   res_pred_taken               prediction that was made at fetch
//   res_target, res_pc_plus4     taken and fall-through PCs
//   out_valid, out_taken         registered result valid / outcome
//   out_mispredict, redirect_pc  registered mispredict flag / correct next PC
//   branch_count                 resolved branches (saturating)
//   mispredict_count             mispredicted branches (saturating)

package branch_predict_pkg;
    // Compare kinds use the RV32 funct3 encoding; 3'd2 and 3'd3 are invalid.
    typedef logic [2:0] branch_t;
    localparam branch_t BR_EQ  = 3'd0;
    localparam branch_t BR_NE  = 3'd1;
    localparam branch_t BR_LT  = 3'd4;
    localparam branch_t BR_GE  = 3'd5;
    localparam branch_t BR_LTU = 3'd6;
    localparam branch_t BR_GEU = 3'd7;
endpackage

module branch_predict_unit
    import branch_predict_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [XLEN-1:0]  res_rs1,
    input  logic [XLEN-1:0]  res_rs2,
    input  branch_t          res_type,
    input  logic             res_pred_taken,
    input  logic [XLEN-1:0]  res_target,
    input  logic [XLEN-1:0]  res_pc_plus4,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_type_ok;
    logic             w_taken;
    logic             w_req;
    logic             w_mispredict;
    logic [1:0]       w_cnt_cur;
    logic [1:0]       w_cnt_next;

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_res_idx  = res_pc[IDX_W+1:2];

    // Read is from the registered table, so a same-cycle resolve to the same
    // entry is only seen by the prediction on the following cycle.
    assign pred_taken = r_bht[w_pred_idx][1];

    always_comb begin
        w_type_ok = 1'b0;
        w_taken   = 1'b0;
        case (res_type)
            BR_EQ:   begin w_type_ok = 1'b1; w_taken = (res_rs1 == res_rs2); end
            BR_NE:   begin w_type_ok = 1'b1; w_taken = (res_rs1 != res_rs2); end
            BR_LT:   begin w_type_ok = 1'b1; w_taken = ($signed(res_rs1) <  $signed(res_rs2)); end
            BR_GE:   begin w_type_ok = 1'b1; w_taken = ($signed(res_rs1) >= $signed(res_rs2)); end
            BR_LTU:  begin w_type_ok = 1'b1; w_taken = (res_rs1 <  res_rs2); end
            BR_GEU:  begin w_type_ok = 1'b1; w_taken = (res_rs1 >= res_rs2); end
            default: begin w_type_ok = 1'b0; w_taken = 1'b0; end
        endcase
    end

    assign w_req        = res_valid && w_type_ok;
    assign w_mispredict = (w_taken != res_pred_taken);
    assign w_cnt_cur    = r_bht[w_res_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_taken) begin
            if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'd1;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_mispredict   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            out_valid <= w_req;
            if (w_req) begin
                r_bht[w_res_idx] <= w_cnt_next;
                out_taken        <= w_taken;
                out_mispredict   <= w_mispredict;
                redirect_pc      <= w_taken ? res_target : res_pc_plus4;
                if (!(&branch_count)) begin
                    branch_count <= branch_count + CNT_W'(1);
                end
                if (w_mispredict && !(&mispredict_count)) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                        res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard testbench for branch_predict_unit

module tb_branch_predict_unit;
    import branch_predict_pkg::*;

    localparam int XLEN = 32;
    localparam int NENT = 64;
    localparam int CW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            res_valid;
    logic [XLEN-1:0] res_pc, res_rs1, res_rs2, res_target, res_pc_plus4;
    branch_t         res_type;
    logic            res_pred_taken;
    logic            out_valid, out_taken, out_mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   branch_count, mispredict_count;

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc),
        .res_rs1(res_rs1), .res_rs2(res_rs2), .res_type(res_type),
        .res_pred_taken(res_pred_taken),
        .res_target(res_target), .res_pc_plus4(res_pc_plus4),
        .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
        .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic            v;
        logic            t;
        logic            m;
        logic [XLEN-1:0] rd;
        logic [CW-1:0]   bc;
        logic [CW-1:0]   mc;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          m_out;
    logic [1:0]    m_bht [NENT];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] idx_of(input logic [XLEN-1:0] pc);
        idx_of = pc[7:2];
    endfunction

    function automatic logic ref_taken(input branch_t ty, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b, output logic ok);
        ok = 1'b1;
        case (ty)
            BR_EQ:   ref_taken = (a == b);
            BR_NE:   ref_taken = (a != b);
            BR_LT:   ref_taken = (a[31] != b[31]) ? a[31] : (a < b);
            BR_GE:   ref_taken = !((a[31] != b[31]) ? a[31] : (a < b));
            BR_LTU:  ref_taken = (a < b);
            BR_GEU:  ref_taken = !(a < b);
            default: begin ok = 1'b0; ref_taken = 1'b0; end
        endcase
    endfunction

    // One clock: drive, check the combinational prediction before the edge,
    // push the expected registered result, then pop and compare after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [XLEN-1:0] pc,
                         input branch_t ty, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic pt, input logic [XLEN-1:0] ppc);
        exp_t e;
        logic ok, tk;
        rst_n          = !rst;
        res_valid      = v;
        res_pc         = pc;
        res_type       = ty;
        res_rs1        = a;
        res_rs2        = b;
        res_pred_taken = pt;
        res_target     = pc + 32'h0000_1000;
        res_pc_plus4   = pc + 32'd4;
        pred_pc        = ppc;
        #1;
        check("pred_taken", {63'd0, pred_taken}, {63'd0, m_bht[idx_of(ppc)][1]});
        tk = ref_taken(ty, a, b, ok);
        if (rst) begin
            for (int i = 0; i < NENT; i++) m_bht[i] = 2'b01;
            m_out = '{v: 1'b0, t: 1'b0, m: 1'b0, rd: '0, bc: '0, mc: '0};
        end else if (v && ok) begin
            m_out.v  = 1'b1;
            m_out.t  = tk;
            m_out.m  = (tk != pt);
            m_out.rd = tk ? pc + 32'h0000_1000 : pc + 32'd4;
            m_out.bc = m_out.bc + 1;
            if (tk != pt) m_out.mc = m_out.mc + 1;
            if (tk && m_bht[idx_of(pc)] != 2'b11) m_bht[idx_of(pc)] = m_bht[idx_of(pc)] + 2'd1;
            if (!tk && m_bht[idx_of(pc)] != 2'b00) m_bht[idx_of(pc)] = m_bht[idx_of(pc)] - 2'd1;
        end else begin
            m_out.v = 1'b0;
        end
        sb_q.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("out_valid",      {63'd0, out_valid},      {63'd0, e.v});
        check("out_taken",      {63'd0, out_taken},      {63'd0, e.t});
        check("out_mispredict", {63'd0, out_mispredict}, {63'd0, e.m});
        check("redirect_pc",    {32'd0, redirect_pc},    {32'd0, e.rd});
        check("branch_count",   {32'd0, branch_count},   {32'd0, e.bc});
        check("mispred_count",  {32'd0, mispredict_count}, {32'd0, e.mc});
    endtask

    task automatic idle(input logic [XLEN-1:0] ppc);
        cycle(1'b0, 1'b0, 32'h0, BR_EQ, 32'h0, 32'h0, 1'b0, ppc);
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) m_bht[i] = 2'b01;
        m_out = '{v: 1'b0, t: 1'b0, m: 1'b0, rd: '0, bc: '0, mc: '0};

        // Reset, with res_valid asserted to prove it is masked.
        cycle(1'b1, 1'b1, 32'h40, BR_EQ, 32'h0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40, BR_EQ, 32'h0, 32'h0, 1'b0, 32'h40);
        for (int i = 0; i < 4; i++) idle(32'(i * 4 + 32'h200));

        // Signed vs unsigned compare of the same operands.
        cycle(1'b0, 1'b1, 32'h200, BR_LT,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'h200);
        cycle(1'b0, 1'b1, 32'h204, BR_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h200);

        // Counter ramp and decay at 0x100.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h100, BR_EQ, 32'd7, 32'd7, 1'b1, 32'h100);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 32'h100, BR_NE, 32'd7, 32'd7, 1'b1, 32'h100);
        idle(32'h100);

        // Same-cycle read and write of one entry.
        cycle(1'b0, 1'b1, 32'h40, BR_GE, 32'd5, 32'd5, 1'b0, 32'h40);
        idle(32'h40);

        // Aliasing: 0x0 trains the entry that 0x100 predicts from.
        cycle(1'b0, 1'b1, 32'h0, BR_GEU, 32'd9, 32'd3, 1'b0, 32'h100);
        idle(32'h100);

        // Invalid compare kinds are ignored.
        cycle(1'b0, 1'b1, 32'h0, branch_t'(3'd2), 32'd1, 32'd1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0, branch_t'(3'd3), 32'd1, 32'd2, 1'b1, 32'h100);
        idle(32'h0);

        // Random back-to-back traffic over all compare kinds.
        for (int i = 0; i < 40; i++) begin
            logic [XLEN-1:0] a, b, pc;
            a  = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
            b  = $urandom_range(0, 3) == 0 ? a : $urandom;
            pc = {22'd0, $urandom_range(0, 15), 2'b00};
            cycle(1'b0, $urandom_range(0, 5) != 0, pc, branch_t'($urandom_range(0, 7)),
                  a, b, 1'($urandom_range(0, 1)), {22'd0, $urandom_range(0, 15), 2'b00});
        end

        // Mid-stream reset with a taken request pending.
        cycle(1'b0, 1'b1, 32'h40, BR_EQ, 32'd1, 32'd1, 1'b0, 32'h40);
        cycle(1'b1, 1'b1, 32'h40, BR_EQ, 32'd1, 32'd1, 1'b0, 32'h40);
        idle(32'h40);
        idle(32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, number of 2-bit counters; power of two, >=2; IDX_W = log2(BHT_ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pred_pc  input  XLEN  fetch PC to predict.
REQ-007 SHALL have port pred_taken  output  1  combinational prediction for pred_pc.
REQ-008 SHALL have port res_valid  input  1  resolve request this cycle.
REQ-009 SHALL have port res_pc  input  XLEN  PC of resolving branch.
REQ-010 SHALL have ports res_rs1, res_rs2  input  XLEN  compare operands.
REQ-011 SHALL have port res_type  input  branch_t  compare kind (BR_EQ/NE/LT/GE/LTU/GEU).
REQ-012 SHALL have port res_pred_taken  input  1  prediction made at fetch.
REQ-013 SHALL have ports res_target, res_pc_plus4  input  XLEN  taken / fall-through PCs.
REQ-014 SHALL have port out_valid  output  1  registered result valid.
REQ-015 SHALL have ports out_taken, out_mispredict  output  1  registered outcome / mispredict flag.
REQ-016 SHALL have port redirect_pc  output  XLEN  registered correct next PC.
REQ-017 SHALL have ports branch_count, mispredict_count  output  CNT_W  statistics.

Function
REQ-018 SHALL index BHT by pc[IDX_W+1:2] for both prediction and resolution.
REQ-019 SHALL drive pred_taken = bit 1 of BHT[index(pred_pc)], zero-latency.
REQ-020 SHALL compute taken: EQ ==, NE !=, LT/GE signed XLEN, LTU/GEU unsigned XLEN.
REQ-021 SHALL treat any other res_type as invalid: request ignored (no BHT update, no counters, out_valid=0 next cycle).
REQ-022 SHALL, on valid request, register result with latency 1: out_valid=1, out_taken=taken, out_mispredict=(taken!=res_pred_taken), redirect_pc=taken?res_target:res_pc_plus4.
REQ-023 SHALL drive out_valid=0 in any cycle following no valid request; other out_* then hold previous values.
REQ-024 SHALL update BHT counter on valid request: taken -> +1 saturating at 2'b11; not taken -> -1 saturating at 2'b00.
REQ-025 SHALL return pre-update counter when pred_pc and res_pc hit same index in same cycle (write visible next cycle).
REQ-026 SHALL increment branch_count per valid request and mispredict_count per mispredict, each saturating at all-ones.
REQ-027 SHALL accept back-to-back requests every cycle, no stall, no backpressure.

Reset
REQ-028 SHALL, on clk edge with rst_n=0, set all BHT counters to 2'b01, out_valid/out_taken/out_mispredict=0, redirect_pc=0, both counts=0.
REQ-029 SHALL ignore res_valid during reset cycles; first result out_valid one cycle after first valid request with rst_n=1.
REQ-030 SHALL make pred_taken=0 for every PC after reset.

Verification
REQ-031 SHALL cover: reset, BR_LT rs1=32'hFFFFFFFF, rs2=1, pred=0 -> next cycle out_taken=1, out_mispredict=1, redirect_pc=res_target, both counts=1.
REQ-032 SHALL cover: BR_LTU same operands, pred=0 -> out_taken=0, out_mispredict=0, redirect_pc=res_pc_plus4.
REQ-033 SHALL cover: four taken resolves at pc=0x100 -> counter 01->10->11->11; pred_taken(0x100)=1 from cycle after first; then two not-taken -> 01, pred_taken=0.
REQ-034 SHALL cover: pred_pc=res_pc=0x40, counter 01, taken resolve same cycle -> pred_taken=0 that cycle, 1 next cycle.
REQ-035 SHALL cover: aliasing pc 0x0 and 0x100 (BHT_ENTRIES=64) share counter; invalid res_type with res_valid=1 -> out_valid=0, counts unchanged.
REQ-036 SHALL cover: rst_n low mid-stream with res_valid=1 -> all outputs/counters zero, BHT back to 01, no update from masked requests.
